// File: rtl/fp_addsub.sv
// Multi-cycle floating-point adder/subtractor with parameterised field widths.
// Each operation walks a fixed seven-state sequence, so latency is constant for
// every operand class, special values included. Subnormals are flushed to zero.
module fp_addsub #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [EXP_W+MAN_W:0]   data_a,
   input  logic [EXP_W+MAN_W:0]   data_b,
   input  logic                   operation,
   input  logic                   input_rdy,
   output logic                   input_ack,
   output logic                   output_rdy,
   input  logic                   output_ack,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [3:0]             flags
);

   localparam int unsigned W     = 1 + EXP_W + MAN_W;
   localparam int unsigned SIG_W = MAN_W + 1;  // significand with hidden bit
   localparam int unsigned EXT_W = MAN_W + 4;  // significand + guard/round/sticky
   localparam int unsigned SUM_W = MAN_W + 5;  // plus carry-out
   localparam int unsigned E_W   = EXP_W + 8;  // signed working exponent
   localparam int unsigned LZ_W  = $clog2(SUM_W + 1);
   localparam logic signed [E_W-1:0] EXP_MAX = E_W'((1 << EXP_W) - 1);

   typedef enum logic [2:0] {
      StIdle, StUnpack, StAlign, StAdd, StNorm, StRound, StDone
   } state_t;

   state_t state_q, state_d;

   logic [W-1:0]            a_q, b_q;
   logic                    op_q;
   logic                    spec_q, spec_d;
   logic [W-1:0]            spec_res_q, spec_res_d;
   logic [3:0]              spec_flags_q, spec_flags_d;
   logic                    sign_big_q, sign_big_d;
   logic                    eff_sub_q, eff_sub_d;
   logic [EXP_W-1:0]        exp_big_q, exp_big_d;
   logic [EXP_W-1:0]        diff_q, diff_d;
   logic [SIG_W-1:0]        sig_big_q, sig_big_d;
   logic [SIG_W-1:0]        sig_small_q, sig_small_d;
   logic [EXT_W-1:0]        small_ext_q, small_ext_d;
   logic [SUM_W-1:0]        sum_q, sum_d;
   logic                    res_sign_q, res_sign_d;
   logic [EXT_W-1:0]        norm_sig_q, norm_sig_d;
   logic signed [E_W-1:0]   norm_exp_q, norm_exp_d;
   logic                    ftz_q, ftz_d;
   logic                    zero_q, zero_d;
   logic [W-1:0]            result_q, result_d;
   logic [3:0]              flags_q, flags_d;

   logic capture;
   assign capture    = (state_q == StIdle) && input_rdy;
   assign input_ack  = (state_q == StUnpack);
   assign output_rdy = (state_q == StDone);
   assign result     = result_q;
   assign flags      = flags_q;

   // Next-state logic: fixed walk through the datapath stages.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (input_rdy) state_d = StUnpack;
         StUnpack: state_d = StAlign;
         StAlign:  state_d = StAdd;
         StAdd:    state_d = StNorm;
         StNorm:   state_d = StRound;
         StRound:  state_d = StDone;
         StDone:   if (output_ack) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Unpack: classify operands, flush subnormals, order by magnitude.
   always_comb begin
      logic                   a_sign, b_sign, a_zero, b_zero, a_ones, b_ones;
      logic                   a_nan, b_nan, a_inf, b_inf, a_big;
      logic [EXP_W-1:0]       a_exp, b_exp;
      logic [MAN_W-1:0]       a_man, b_man;
      logic [EXP_W+MAN_W-1:0] a_mag, b_mag;
      logic [SIG_W-1:0]       a_sig, b_sig;
      a_sign = a_q[W-1];
      b_sign = b_q[W-1] ^ op_q;
      a_exp  = a_q[W-2:MAN_W];
      b_exp  = b_q[W-2:MAN_W];
      a_man  = a_q[MAN_W-1:0];
      b_man  = b_q[MAN_W-1:0];
      a_zero = (a_exp == '0);
      b_zero = (b_exp == '0);
      a_ones = &a_exp;
      b_ones = &b_exp;
      a_nan  = a_ones && (a_man != '0);
      b_nan  = b_ones && (b_man != '0);
      a_inf  = a_ones && (a_man == '0);
      b_inf  = b_ones && (b_man == '0);
      a_mag  = a_zero ? '0 : {a_exp, a_man};
      b_mag  = b_zero ? '0 : {b_exp, b_man};
      a_sig  = a_zero ? '0 : {1'b1, a_man};
      b_sig  = b_zero ? '0 : {1'b1, b_man};
      a_big  = (a_mag >= b_mag);

      sign_big_d  = a_big ? a_sign : b_sign;
      exp_big_d   = a_big ? a_mag[EXP_W+MAN_W-1:MAN_W] : b_mag[EXP_W+MAN_W-1:MAN_W];
      diff_d      = a_big ? a_mag[EXP_W+MAN_W-1:MAN_W] - b_mag[EXP_W+MAN_W-1:MAN_W]
                          : b_mag[EXP_W+MAN_W-1:MAN_W] - a_mag[EXP_W+MAN_W-1:MAN_W];
      sig_big_d   = a_big ? a_sig : b_sig;
      sig_small_d = a_big ? b_sig : a_sig;
      eff_sub_d   = a_sign ^ b_sign;

      spec_d       = 1'b0;
      spec_res_d   = '0;
      spec_flags_d = 4'b0000;
      if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
         spec_d       = 1'b1;
         spec_res_d   = {W{1'b1}};
         spec_flags_d = 4'b1000;
      end else if (a_inf) begin
         spec_d     = 1'b1;
         spec_res_d = {a_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (b_inf) begin
         spec_d     = 1'b1;
         spec_res_d = {b_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
   end

   // Align: shift the smaller significand right, folding lost bits into sticky.
   always_comb begin
      logic [2*EXT_W-1:0] wide;
      wide = {sig_small_q, 3'b000, {EXT_W{1'b0}}} >> diff_q;
      if (32'(diff_q) >= MAN_W + 3) begin
         small_ext_d = {{(EXT_W-1){1'b0}}, |sig_small_q};
      end else begin
         small_ext_d    = wide[2*EXT_W-1:EXT_W];
         small_ext_d[0] = wide[EXT_W] | (|wide[EXT_W-1:0]);
      end
   end

   // Add: magnitude add/subtract; big >= small so the difference never goes negative.
   always_comb begin
      logic [SUM_W-1:0] big_ext, small_ext;
      big_ext   = {1'b0, sig_big_q, 3'b000};
      small_ext = {1'b0, small_ext_q};
      sum_d     = eff_sub_q ? (big_ext - small_ext) : (big_ext + small_ext);
      // Exact cancellation yields +0; like-signed zeros keep their sign.
      res_sign_d = (eff_sub_q && (sum_d == '0)) ? 1'b0 : sign_big_q;
   end

   // Norm: single-cycle leading-one detect, then one shift in either direction.
   always_comb begin
      logic [LZ_W-1:0] lead, shift;
      logic            found;
      lead  = '0;
      found = 1'b0;
      for (int i = SUM_W - 1; i >= 0; i--) begin
         if (!found && sum_q[i]) begin
            lead  = LZ_W'(i);
            found = 1'b1;
         end
      end
      shift      = LZ_W'(SUM_W - 2) - lead;
      zero_d     = (sum_q == '0);
      norm_sig_d = '0;
      norm_exp_d = '0;
      if (sum_q[SUM_W-1]) begin
         norm_sig_d = {sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
         norm_exp_d = $signed({{(E_W-EXP_W){1'b0}}, exp_big_q}) + E_W'(1);
      end else if (!zero_d) begin
         norm_sig_d = sum_q[EXT_W-1:0] << shift;
         norm_exp_d = $signed({{(E_W-EXP_W){1'b0}}, exp_big_q})
                      - $signed({{(E_W-LZ_W){1'b0}}, shift});
      end
      ftz_d = !zero_d && (norm_exp_d[E_W-1] || (norm_exp_d == '0));
   end

   // Round: nearest-even, then overflow to infinity; specials bypass the datapath.
   always_comb begin
      logic                  guard, sticky, lsb, up, inexact;
      logic [SIG_W:0]        rnd;
      logic signed [E_W-1:0] exp_r;
      logic [MAN_W-1:0]      frac;
      guard   = norm_sig_q[2];
      sticky  = |norm_sig_q[1:0];
      lsb     = norm_sig_q[3];
      up      = guard && (sticky || lsb);
      inexact = |norm_sig_q[2:0];
      rnd     = {1'b0, norm_sig_q[EXT_W-1:3]} + {{SIG_W{1'b0}}, up};
      exp_r   = norm_exp_q + $signed({{(E_W-1){1'b0}}, rnd[SIG_W]});
      frac    = rnd[SIG_W] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
      if (spec_q) begin
         result_d = spec_res_q;
         flags_d  = spec_flags_q;
      end else if (zero_q) begin
         result_d = {res_sign_q, {(W-1){1'b0}}};
         flags_d  = 4'b0001;
      end else if (ftz_q) begin
         result_d = {res_sign_q, {(W-1){1'b0}}};
         flags_d  = 4'b0011;
      end else if (exp_r >= EXP_MAX) begin
         result_d = {res_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags_d  = 4'b0110;
      end else begin
         result_d = {res_sign_q, exp_r[EXP_W-1:0], frac};
         flags_d  = {2'b00, inexact, 1'b0};
      end
   end

   // State and per-stage pipeline registers, each loaded in its own state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StIdle;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= 1'b0;
         spec_q       <= 1'b0;
         spec_res_q   <= '0;
         spec_flags_q <= '0;
         sign_big_q   <= 1'b0;
         eff_sub_q    <= 1'b0;
         exp_big_q    <= '0;
         diff_q       <= '0;
         sig_big_q    <= '0;
         sig_small_q  <= '0;
         small_ext_q  <= '0;
         sum_q        <= '0;
         res_sign_q   <= 1'b0;
         norm_sig_q   <= '0;
         norm_exp_q   <= '0;
         ftz_q        <= 1'b0;
         zero_q       <= 1'b0;
         result_q     <= '0;
         flags_q      <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            a_q  <= data_a;
            b_q  <= data_b;
            op_q <= operation;
         end
         if (state_q == StUnpack) begin
            spec_q       <= spec_d;
            spec_res_q   <= spec_res_d;
            spec_flags_q <= spec_flags_d;
            sign_big_q   <= sign_big_d;
            eff_sub_q    <= eff_sub_d;
            exp_big_q    <= exp_big_d;
            diff_q       <= diff_d;
            sig_big_q    <= sig_big_d;
            sig_small_q  <= sig_small_d;
         end
         if (state_q == StAlign) small_ext_q <= small_ext_d;
         if (state_q == StAdd) begin
            sum_q      <= sum_d;
            res_sign_q <= res_sign_d;
         end
         if (state_q == StNorm) begin
            norm_sig_q <= norm_sig_d;
            norm_exp_q <= norm_exp_d;
            ftz_q      <= ftz_d;
            zero_q     <= zero_d;
         end
         if (state_q == StRound) begin
            result_q <= result_d;
            flags_q  <= flags_d;
         end
      end
   end

endmodule

// File: doc/fp_addsub.md
FP_ADDSUB -- requirements
Module: fp_addsub

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (range 3..11).
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width (range 4..52); W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port data_a  input  W  operand A, IEEE-754-style {sign, exponent, fraction}.
REQ-006 SHALL have port data_b  input  W  operand B, same format.
REQ-007 SHALL have port operation  input  1  0 = A+B, 1 = A-B; sampled with the operands.
REQ-008 SHALL have port input_rdy  input  1  producer asserts while data_a/data_b/operation are valid.
REQ-009 SHALL have port input_ack  output  1  one-cycle pulse: operands captured.
REQ-010 SHALL have port output_rdy  output  1  result and flags valid.
REQ-011 SHALL have port output_ack  input  1  consumer has taken the result.
REQ-012 SHALL have port result  output  W  sum/difference.
REQ-013 SHALL have port flags  output  4  {invalid, overflow, inexact, zero}.

Function
REQ-014 SHALL implement FSM IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE; no other transitions except reset.
REQ-015 SHALL capture operands and operation on an edge in IDLE with input_rdy=1, enter UNPACK, and drive input_ack=1 for exactly the following cycle.
REQ-016 SHALL ignore input_rdy in every state except IDLE; no ack, no capture.
REQ-017 SHALL advance one state per clock from UNPACK to DONE; output_rdy rises 5 edges after the capture edge, for every operand class including specials.
REQ-018 SHALL hold result, flags, output_rdy=1 stable in DONE until output_ack=1 is sampled; then go IDLE with output_rdy=0 next cycle.
REQ-019 SHALL ignore output_ack outside DONE.
REQ-020 SHALL NOT capture a new operand on the same edge that releases DONE; earliest next capture is the following edge (IDLE).
REQ-021 SHALL treat operation=1 as inversion of B sign before addition.
REQ-022 SHALL flush subnormal inputs (exp=0) to signed zero and flush results below minimum normal to signed zero with inexact=1 (FTZ).
REQ-023 SHALL align by shifting the smaller-magnitude significand right, keeping guard, round and sticky bits; shift >= MAN_W+3 collapses to sticky only.
REQ-024 SHALL normalise with a single-cycle leading-zero count in NORM (no iterative shifting); carry-out shifts right by one and increments exponent.
REQ-025 SHALL round to nearest, ties to even; inexact=1 when any of guard/round/sticky is nonzero.
REQ-026 SHALL produce +inf/-inf (exp all ones, fraction 0) with overflow=1, inexact=1 when rounded exponent reaches all ones.
REQ-027 SHALL return canonical NaN (all W bits 1) with invalid=1 when either input is NaN or for inf minus inf of same effective sign difference.
REQ-028 SHALL return inf with that operand's sign for inf plus finite, and inf for same-signed inf plus inf; flags 0.
REQ-029 SHALL return +0 for exact cancellation of finite nonzero operands; -0 only for (-0)+(-0); zero=1 whenever result is +/-0.

Reset
REQ-030 SHALL on reset=1 at any edge, in any state, go IDLE, drop in-flight operation, drive input_ack=0, output_rdy=0, result=0, flags=0 from the next cycle.
REQ-031 SHALL not capture operands on an edge where reset=1, regardless of input_rdy.

Verification
REQ-032 SHALL pass: defaults, A=32'h3F800000, B=32'h3C23D70A, op=0 -> result 32'h3F8147AE, flags 4'b0010, output_rdy 5 edges after capture.
REQ-033 SHALL pass: A=32'h3F800000, B=32'h33800000 (tie) -> 32'h3F800000 inexact; B=32'h33C00000 -> 32'h3F800001 inexact.
REQ-034 SHALL pass: A=B=32'h3F800000, op=1 -> 32'h00000000, flags 4'b0001; A=B=32'h7F7FFFFF, op=0 -> 32'h7F800000, flags 4'b0110.
REQ-035 SHALL pass: A=32'h7F800000, B=32'h7F800000, op=1 -> 32'hFFFFFFFF, flags 4'b1000; A=32'hFF800000, B=32'h3F800000 -> 32'hFF800000, flags 0.
REQ-036 SHALL pass: EXP_W=5, MAN_W=10, A=B=16'h3C00, op=0 -> 16'h4000; result held while output_ack=0 for 10 cycles.
REQ-037 SHALL pass: reset asserted in ALIGN -> output_rdy never rises; next operation after reset completes with correct latency and value.
